dsp_mac_pipe: RTL
=================

// Module: dsp_mac_pipe
// PURPOSE
//  Parametrised, pipelined multiply/add/accumulate slice: next generation of the 16-bit DSP slice.
//  Adds configurable operand/accumulator width, multiplier pipeline depth, signed/unsigned
//  operation per op, per-op mode tagging, cascade chaining and a sticky overflow flag.
//  Sits in DSP columns of the benchmark datapaths; chains vertically via cascade_in/cascade_out.
// PARAMETERS
//  DWIDTH       16  operand width of a_in/b_in
//  ACC_WIDTH    40  accumulator/result width; must be >= 2*DWIDTH
//  MULT_STAGES  2   multiplier pipeline register stages, legal range 1..4
// PORTS
//  clk          in   1          clock, all state on posedge
//  reset        in   1          synchronous, active-high
//  in_valid     in   1          op present on inputs this cycle
//  mode         in   2          00=ADD 01=MUL 10=MAC 11=CASCADE (sampled with in_valid)
//  is_signed    in   1          1 = two's-complement operands/result for this op
//  acc_clear    in   1          with a MAC op: load instead of accumulate; clears overflow
//  a_in         in   DWIDTH     operand A
//  b_in         in   DWIDTH     operand B
//  cascade_in   in   ACC_WIDTH  partial sum from slice below (used in CASCADE mode)
//  out_valid    out  1          c_out holds a new result
//  c_out        out  ACC_WIDTH  registered result
//  cascade_out  out  ACC_WIDTH  equals c_out; feeds the slice above
//  overflow     out  1          sticky overflow of MAC/CASCADE sums
// BEHAVIOUR
//  - Reset: out_valid=0, c_out=0, overflow=0, accumulator=0, all pipeline valid bits cleared;
//    ops in flight are discarded; first new op accepted the cycle after reset deasserts.
//  - Pipeline: input reg (1) + MULT_STAGES + result reg (1); latency L=MULT_STAGES+2 cycles.
//    One op per cycle, no backpressure; mode/is_signed/acc_clear travel with their op.
//  - Signed ops sign-extend operands/results to ACC_WIDTH; unsigned ops zero-extend.
//  - in_valid=0 cycles are bubbles: out_valid=0 L cycles later; c_out and accumulator hold.
//  - ADD: c_out = ext(a)+ext(b). MUL: c_out = ext(a*b). Neither touches accumulator/overflow.
//  - MAC: sum = acc + ext(a*b); acc<=sum, c_out<=sum. With acc_clear: acc<=ext(a*b),
//    c_out<=ext(a*b), overflow<=0.
//  - CASCADE: c_out = cascade_in + ext(a*b); accumulator unchanged.
//  - acc_clear is ignored when in_valid=0 and in ADD/MUL/CASCADE ops.
//  - Overflow: signed = operand signs equal and result sign differs; unsigned = carry out of
//    ACC_WIDTH. Sets overflow (sticky) for MAC/CASCADE. Cleared only by reset or MAC+acc_clear.
//  - Back-to-back MACs: accumulator update is single-cycle in the result stage, so
//    consecutive MAC ops see each other's result (no hazard bubbles needed).
// CONFIGURATION
//  DSP_SATURATE_EN defined: an overflowing MAC/CASCADE sum clamps to the max/min of ACC_WIDTH
//    (signed: 0x7F..F / 0x80..0; unsigned: 0xFF..F) in both accumulator and c_out.
//  Not defined: sums wrap modulo 2^ACC_WIDTH. overflow flag behaves identically in both builds.
// TESTING  (DWIDTH=16, ACC_WIDTH=40, MULT_STAGES=2, L=4)
//  1. Reset for 2 cycles with 3 ops in flight -> out_valid=0, c_out=0, overflow=0; no stale output.
//  2. MUL unsigned a=0xFFFF b=0xFFFF at cycle t -> out_valid=1, c_out=0x00FFFE0001 at t+4.
//  3. Signed MAC back-to-back (3,4,clear),(-2,5),(7,7) -> c_out 12, 2, 51 on consecutive cycles.
//  4. ADD signed a=0x8000 b=0xFFFF -> c_out=0xFFFFFF7FFF; accumulator unchanged (next MAC checks).
//  5. CASCADE signed cascade_in=0x7FFFFFFFFF, a=1 b=1 -> overflow=1; c_out=0x8000000000 (wrap)
//     or 0x7FFFFFFFFF with DSP_SATURATE_EN; overflow stays 1 until a MAC with acc_clear.
//  6. Random in_valid gaps, mixed modes/is_signed per op -> each result matches a reference
//     model L cycles later; bubbles give out_valid=0 and held c_out.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply/add/accumulate DSP slice with cascade chaining and sticky overflow.
// Define DSP_SATURATE_EN to clamp overflowing MAC/CASCADE sums instead of wrapping.
module dsp_mac_pipe #(
  parameter int DWIDTH      = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int MULT_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic                 is_signed,
  input  logic                 acc_clear,
  input  logic [DWIDTH-1:0]    a_in,
  input  logic [DWIDTH-1:0]    b_in,
  input  logic [ACC_WIDTH-1:0] cascade_in,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] c_out,
  output logic [ACC_WIDTH-1:0] cascade_out,
  output logic                 overflow
);
  localparam int LAST = MULT_STAGES - 1;
  localparam int MSB  = ACC_WIDTH - 1;
  localparam logic [1:0] MODE_ADD     = 2'b00;
  localparam logic [1:0] MODE_MUL     = 2'b01;
  localparam logic [1:0] MODE_MAC     = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  logic                 s0_v, s0_sgn, s0_clr;
  logic [1:0]           s0_mode;
  logic [DWIDTH-1:0]    s0_a, s0_b;
  logic [ACC_WIDTH-1:0] s0_casc;

  logic                 m_v    [MULT_STAGES];
  logic [1:0]           m_mode [MULT_STAGES];
  logic                 m_sgn  [MULT_STAGES];
  logic                 m_clr  [MULT_STAGES];
  logic [ACC_WIDTH-1:0] m_val  [MULT_STAGES];
  logic [ACC_WIDTH-1:0] m_casc [MULT_STAGES];

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] a_ext, b_ext, op_val;
  logic [ACC_WIDTH-1:0] res_base, res_val, res_sum, res_mac;
  logic [ACC_WIDTH:0]   res_full;
  logic                 res_ovf;

  // Extending to ACC_WIDTH before multiplying gives ext(a*b) directly for both signednesses.
  always_comb begin
    a_ext  = s0_sgn ? ACC_WIDTH'($signed(s0_a)) : ACC_WIDTH'(s0_a);
    b_ext  = s0_sgn ? ACC_WIDTH'($signed(s0_b)) : ACC_WIDTH'(s0_b);
    op_val = (s0_mode == MODE_ADD) ? (a_ext + b_ext) : (a_ext * b_ext);
  end

  always_comb begin
    res_val = m_val[LAST];
    if (m_mode[LAST] == MODE_CASCADE) res_base = m_casc[LAST];
    else if (m_clr[LAST])             res_base = '0;
    else                              res_base = acc;
    res_full = {1'b0, res_base} + {1'b0, res_val};
    res_sum  = res_full[ACC_WIDTH-1:0];
    if (m_sgn[LAST])
      res_ovf = (res_base[MSB] == res_val[MSB]) && (res_sum[MSB] != res_base[MSB]);
    else
      res_ovf = res_full[ACC_WIDTH];
    res_mac = res_sum;
`ifdef DSP_SATURATE_EN
    if (res_ovf) begin
      if (!m_sgn[LAST])      res_mac = '1;
      else if (res_base[MSB]) res_mac = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                   res_mac = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v    <= 1'b0;
      s0_mode <= '0;
      s0_sgn  <= 1'b0;
      s0_clr  <= 1'b0;
      s0_a    <= '0;
      s0_b    <= '0;
      s0_casc <= '0;
      for (int k = 0; k < MULT_STAGES; k++) begin
        m_v[k]    <= 1'b0;
        m_mode[k] <= '0;
        m_sgn[k]  <= 1'b0;
        m_clr[k]  <= 1'b0;
        m_val[k]  <= '0;
        m_casc[k] <= '0;
      end
      acc       <= '0;
      out_valid <= 1'b0;
      c_out     <= '0;
      overflow  <= 1'b0;
    end else begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_mode <= mode;
        s0_sgn  <= is_signed;
        s0_clr  <= acc_clear;
        s0_a    <= a_in;
        s0_b    <= b_in;
        s0_casc <= cascade_in;
      end
      m_v[0]    <= s0_v;
      m_mode[0] <= s0_mode;
      m_sgn[0]  <= s0_sgn;
      m_clr[0]  <= s0_clr;
      m_val[0]  <= op_val;
      m_casc[0] <= s0_casc;
      for (int k = 1; k < MULT_STAGES; k++) begin
        m_v[k]    <= m_v[k-1];
        m_mode[k] <= m_mode[k-1];
        m_sgn[k]  <= m_sgn[k-1];
        m_clr[k]  <= m_clr[k-1];
        m_val[k]  <= m_val[k-1];
        m_casc[k] <= m_casc[k-1];
      end
      out_valid <= m_v[LAST];
      // Accumulator updates here in one cycle, so back-to-back MACs chain without bubbles.
      if (m_v[LAST]) begin
        case (m_mode[LAST])
          MODE_ADD, MODE_MUL: c_out <= res_val;
          MODE_MAC: begin
            c_out    <= res_mac;
            acc      <= res_mac;
            overflow <= m_clr[LAST] ? 1'b0 : (overflow | res_ovf);
          end
          default: begin
            c_out    <= res_mac;
            overflow <= overflow | res_ovf;
          end
        endcase
      end
    end
  end

  assign cascade_out = c_out;
endmodule
